// File: rtl/sub_pkg.sv
// Shared types and helpers for the sequential subtractor.
// FSM encoding plus counter sizing.
package sub_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Width needed to count 0..v-1, never below one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/chunk_subtractor.sv
// Combinational CHUNK-bit subtract with borrow in/out.
// SUB_OVERFLOW_EN exports the borrow into the MSB.
module chunk_subtractor #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             bin_i,
  output logic [CHUNK-1:0] d_o,
`ifdef SUB_OVERFLOW_EN
  output logic             bmsb_o,
`endif
  output logic             bout_o
);

  logic [CHUNK:0] full;

  assign full   = {1'b0, a_i} - {1'b0, b_i}
                - {{CHUNK{1'b0}}, bin_i};
  assign d_o    = full[CHUNK-1:0];
  assign bout_o = full[CHUNK];

`ifdef SUB_OVERFLOW_EN
  // MSB difference bit is a^b^borrow_in, so recover the borrow.
  assign bmsb_o = a_i[CHUNK-1] ^ b_i[CHUNK-1] ^ d_o[CHUNK-1];
`endif

endmodule

// File: rtl/sequential_subtractor.sv
// Multi-cycle subtractor, CHUNK bits per clock, LSB chunk first.
// Define SUB_OVERFLOW_EN to add the signed-overflow output.
module sequential_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             Clk_i,
  input  logic             Rst_ni,
  input  logic             Valid_i,
  output logic             Ready_o,
  input  logic [WIDTH-1:0] Minuend_i,
  input  logic [WIDTH-1:0] Subtrahend_i,
  input  logic             Borrow_i,
  output logic             Valid_o,
  input  logic             Ready_i,
  output logic [WIDTH-1:0] Result_o,
  output logic             Borrow_o,
`ifdef SUB_OVERFLOW_EN
  output logic             Overflow_o,
`endif
  output logic             Busy_o
);

  localparam int STEPS = WIDTH / CHUNK;
  localparam int CNT_W = clog2(STEPS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic bor_q, bor_d;
  logic bout_q, bout_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] sub_q, sub_d;
  logic [WIDTH-1:0] res_q, res_d;

  logic [CHUNK-1:0] m_ch, s_ch, d_ch;
  logic b_out;
  logic last;

`ifdef SUB_OVERFLOW_EN
  logic ovf_q, ovf_d;
  logic b_msb;
`endif

  assign last = (cnt_q == LAST);

  chunk_subtractor #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a_i    (m_ch),
    .b_i    (s_ch),
    .bin_i  (bor_q),
    .d_o    (d_ch),
`ifdef SUB_OVERFLOW_EN
    .bmsb_o (b_msb),
`endif
    .bout_o (b_out)
  );

  always_ff @(posedge Clk_i or negedge Rst_ni) begin
    if (!Rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bor_q   <= 1'b0;
      bout_q  <= 1'b0;
      min_q   <= '0;
      sub_q   <= '0;
      res_q   <= '0;
`ifdef SUB_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bor_q   <= bor_d;
      bout_q  <= bout_d;
      min_q   <= min_d;
      sub_q   <= sub_d;
      res_q   <= res_d;
`ifdef SUB_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (Valid_i) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (Ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand chunk mux keeps all indices constant.
  always_comb begin
    m_ch = '0;
    s_ch = '0;
    for (int k = 0; k < STEPS; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        m_ch = min_q[k*CHUNK +: CHUNK];
        s_ch = sub_q[k*CHUNK +: CHUNK];
      end
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    bor_d  = bor_q;
    bout_d = bout_q;
    min_d  = min_q;
    sub_d  = sub_q;
    res_d  = res_q;
`ifdef SUB_OVERFLOW_EN
    ovf_d  = ovf_q;
`endif
    if (state_q == IDLE && Valid_i) begin
      min_d = Minuend_i;
      sub_d = Subtrahend_i;
      bor_d = Borrow_i;
      cnt_d = '0;
    end
    if (state_q == RUN) begin
      for (int k = 0; k < STEPS; k++) begin
        if (cnt_q == CNT_W'(k)) res_d[k*CHUNK +: CHUNK] = d_ch;
      end
      bor_d = b_out;
      if (last) begin
        bout_d = b_out;
`ifdef SUB_OVERFLOW_EN
        ovf_d  = b_msb ^ b_out;
`endif
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    Ready_o  = (state_q == IDLE);
    Busy_o   = (state_q == RUN);
    Valid_o  = (state_q == DONE);
    Result_o = res_q;
    Borrow_o = bout_q;
`ifdef SUB_OVERFLOW_EN
    Overflow_o = ovf_q;
`endif
  end

endmodule

// File: tb/tb_sequential_subtractor.sv
// Scoreboard bench for sequential_subtractor (8-bit and 32-bit chunks).
// Define SUB_OVERFLOW_EN to also check Overflow_o.
module tb_sequential_subtractor;

  typedef struct {
    logic [31:0] res;
    logic        bor;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic valid_i = 1'b0, ready_i = 1'b0, bor_i = 1'b0;
  logic [31:0] min_i = '0, sub_i = '0;
  logic ready_o, valid_o, bor_o, busy_o, ovf_o;
  logic [31:0] res_o;

  logic v2 = 1'b0, ri2 = 1'b0, b2 = 1'b0;
  logic [31:0] m2 = '0, s2 = '0;
  logic r2o, vo2, bo2, busy2, ovf2;
  logic [31:0] res2;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sequential_subtractor #(.WIDTH(32), .CHUNK(8)) dut (
    .Clk_i        (clk),
    .Rst_ni       (rst_n),
    .Valid_i      (valid_i),
    .Ready_o      (ready_o),
    .Minuend_i    (min_i),
    .Subtrahend_i (sub_i),
    .Borrow_i     (bor_i),
    .Valid_o      (valid_o),
    .Ready_i      (ready_i),
    .Result_o     (res_o),
    .Borrow_o     (bor_o),
`ifdef SUB_OVERFLOW_EN
    .Overflow_o   (ovf_o),
`endif
    .Busy_o       (busy_o)
  );

  sequential_subtractor #(.WIDTH(32), .CHUNK(32)) dut32 (
    .Clk_i        (clk),
    .Rst_ni       (rst_n),
    .Valid_i      (v2),
    .Ready_o      (r2o),
    .Minuend_i    (m2),
    .Subtrahend_i (s2),
    .Borrow_i     (b2),
    .Valid_o      (vo2),
    .Ready_i      (ri2),
    .Result_o     (res2),
    .Borrow_o     (bo2),
`ifdef SUB_OVERFLOW_EN
    .Overflow_o   (ovf2),
`endif
    .Busy_o       (busy2)
  );

`ifndef SUB_OVERFLOW_EN
  assign ovf_o = 1'b0;
  assign ovf2  = 1'b0;
`endif

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] m,
                                 input logic [31:0] s,
                                 input logic bi);
    logic [32:0] u;
    logic [32:0] sg;
    exp_t e;
    u  = {1'b0, m} - {1'b0, s} - {32'd0, bi};
    sg = {m[31], m} - {s[31], s} - {32'd0, bi};
    e.res = u[31:0];
    e.bor = u[32];
    e.ovf = sg[32] ^ sg[31];
    return e;
  endfunction

  task automatic pop(output exp_t e);
    if (sb.size() > 0) begin
      e = sb.pop_front();
    end else begin
      e = '{res: '0, bor: 1'b0, ovf: 1'b0};
      chk("sb_empty", 32'd0, 32'd1);
    end
  endtask

  // One full transaction on the 8-bit-chunk instance.
  task automatic run_op(input logic [31:0] m, input logic [31:0] s,
                        input logic bi, input int hold);
    exp_t e;
    int n, lat, busy;
    n = 0;
    while (!ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_in", 32'(ready_o), 32'd1);
    min_i = m;
    sub_i = s;
    bor_i = bi;
    valid_i = 1'b1;
    @(posedge clk);
    sb.push_back(model(m, s, bi));
    #1;
    valid_i = 1'b0;
    min_i = $urandom;
    sub_i = $urandom;
    bor_i = ~bi;
    // Latency counts the accepting edge as edge 1.
    lat = 1;
    busy = 0;
    while (!valid_o && lat < 20) begin
      if (busy_o) busy++;
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'd5);
    chk("busy_cycles", 32'(busy), 32'd4);
    pop(e);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      valid_i = i[0];
      chk("hold_valid", 32'(valid_o), 32'd1);
      chk("hold_ready", 32'(ready_o), 32'd0);
      chk("hold_res", res_o, e.res);
      chk("hold_bor", 32'(bor_o), 32'(e.bor));
    end
    @(negedge clk);
    valid_i = 1'b0;
    chk("result", res_o, e.res);
    chk("borrow", 32'(bor_o), 32'(e.bor));
`ifdef SUB_OVERFLOW_EN
    chk("overflow", 32'(ovf_o), 32'(e.ovf));
`endif
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    ready_i = 1'b0;
    chk("ready_after", 32'(ready_o), 32'd1);
    chk("valid_after", 32'(valid_o), 32'd0);
    @(negedge clk);
    chk("idle_hold_res", res_o, e.res);
    chk("idle_busy", 32'(busy_o), 32'd0);
  endtask

  initial begin
    exp_t e;
    int lat;
    #2;
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_res", res_o, 32'd0);
    chk("rst_bor", 32'(bor_o), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 0);
    run_op(32'h0000_0000, 32'h0000_0001, 1'b0, 0);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 0);
    run_op(32'h0000_0003, 32'h0000_0001, 1'b0, 0);
    run_op(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 10);
    for (int i = 0; i < 5; i++) begin
      run_op($urandom, $urandom, 1'($urandom_range(0, 1)), 0);
    end

    // Abort mid-RUN after two chunks.
    min_i = 32'h0000_0000;
    sub_i = 32'h0000_0001;
    bor_i = 1'b0;
    valid_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 32'(ready_o), 32'd1);
    chk("abort_valid", 32'(valid_o), 32'd0);
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_res", res_o, 32'd0);
    chk("abort_bor", 32'(bor_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(32'h0000_0100, 32'h0000_00FF, 1'b1, 0);

    // Single-chunk instance.
    m2 = 32'h1234_5678;
    s2 = 32'h0234_5678;
    b2 = 1'b0;
    chk("c32_ready", 32'(r2o), 32'd1);
    v2 = 1'b1;
    @(posedge clk);
    sb.push_back(model(m2, s2, b2));
    #1;
    v2 = 1'b0;
    lat = 1;
    while (!vo2 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("c32_latency", 32'(lat), 32'd2);
    pop(e);
    chk("c32_result", res2, e.res);
    chk("c32_borrow", 32'(bo2), 32'(e.bor));
`ifdef SUB_OVERFLOW_EN
    chk("c32_overflow", 32'(ovf2), 32'(e.ovf));
`endif
    @(negedge clk);
    ri2 = 1'b1;
    @(posedge clk);
    #1;
    ri2 = 1'b0;
    chk("c32_ready_after", 32'(r2o), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sequential_subtractor.md
Name: sequential_subtractor

Overview:
- Multi-cycle unsigned/two's-complement subtractor: Result = Minuend - Subtrahend - Borrow_in.
- Processes CHUNK bits per clock, least-significant chunk first, holding the borrow in a flop between chunks.
- Sits alongside the combinational adders in the arithmetic library as the area-lean, handshaked inverse operation for datapaths that can tolerate multi-cycle latency.

Parameters:
- WIDTH, 32: operand and result width in bits.
- CHUNK, 8: bits processed per cycle. WIDTH % CHUNK must be 0 and CHUNK >= 1. STEPS = WIDTH/CHUNK.

Ports:
- Clk_i  input  1  single clock, rising edge.
- Rst_ni  input  1  asynchronous, active-low reset.
- Valid_i  input  1  operands valid.
- Ready_o  output  1  block can accept operands.
- Minuend_i  input  WIDTH  minuend.
- Subtrahend_i  input  WIDTH  subtrahend.
- Borrow_i  input  1  borrow-in at the LSB.
- Valid_o  output  1  result valid.
- Ready_i  input  1  consumer accepts result.
- Result_o  output  WIDTH  difference.
- Borrow_o  output  1  borrow-out of the MSB (1 = unsigned underflow).
- Busy_o  output  1  operation in progress (RUN state).

Behaviour:
- Interface: one clock Clk_i. Reset Rst_ni is asynchronous and active-low.
- FSM states: IDLE, RUN, DONE. Encoding IDLE=2'b00, RUN=2'b01, DONE=2'b10.
- Reset (asynchronous, while Rst_ni=0):
  - State goes to IDLE; chunk counter, borrow flop, operand and result registers clear to 0.
  - Output values: Ready_o=1, Valid_o=0, Busy_o=0, Result_o=0, Borrow_o=0.
- IDLE:
  - Ready_o=1.
  - On Valid_i && Ready_o at a clock edge: capture Minuend_i, Subtrahend_i and Borrow_i into internal registers; counter=0; go to RUN.
- RUN:
  - Ready_o=0, Busy_o=1.
  - Each cycle, chunk k=counter computes {b_out, d} = M[k] - S[k] - b_flop, where b_flop starts at Borrow_i.
  - Writes d into result bits [k*CHUNK +: CHUNK]; b_flop <= b_out; counter++.
  - After the cycle processing chunk STEPS-1, go to DONE.
- DONE:
  - Valid_o=1; Result_o and Borrow_o are registered and stable.
  - On Ready_i=1 at a clock edge, go to IDLE.
  - Ready_o=0 in DONE, so back-to-back operations are spaced at a minimum of STEPS+2 cycles.
- Latency: Valid_o rises STEPS+1 clock edges after the accepting edge (5 cycles for the defaults).
- Output holding:
  - Result_o and Borrow_o hold their value from DONE through IDLE until the next result is written.
  - Result chunks update in place during RUN; Result_o is valid only while Valid_o=1.
- Operand changes after acceptance are ignored.
- Valid_i asserted in RUN or DONE is not consumed; the upstream must hold it.
- Ready_i outside DONE has no effect.
- CHUNK==WIDTH: STEPS=1, a single RUN cycle.
- Counter width is clog2(STEPS), minimum 1 bit. The counter is compared against STEPS-1 and never wraps beyond it.
- Reset asserted mid-RUN or mid-DONE aborts the operation immediately: outputs take their reset values and no partial result is presented.

Optional Feature:
- Macro SUB_OVERFLOW_EN.
- Defined:
  - Adds port Overflow_o (output, 1 bit) = signed overflow = (borrow into MSB) XOR (borrow out of MSB).
  - Registered on the final RUN cycle; valid with Valid_o; held like Result_o; reset value 0.
- Undefined: port and logic are absent; interface is otherwise identical.

Decomposition:
- Shared package/include sub_pkg:
  - FSM state encodings and state width constant.
  - clog2 function for counter sizing.
- Sub-module chunk_subtractor: combinational CHUNK-bit subtract with borrow in/out, plus an exported borrow-into-MSB used for overflow.
- sequential_subtractor instantiates one chunk_subtractor and multiplexes operand chunks by counter.

Test Plan:
1. Basic subtract: 0x00000005 - 0x00000003, Borrow_i=0 -> Result_o=0x00000002, Borrow_o=0; Valid_o high exactly 5 cycles after the accept edge; Busy_o high for 4 cycles.
2. Full ripple: 0x00000000 - 0x00000001 -> Result_o=0xFFFFFFFF, Borrow_o=1; the borrow propagates across all 4 chunks.
3. Signed overflow: 0x80000000 - 0x00000001 -> Result_o=0x7FFFFFFF, Borrow_o=0. With SUB_OVERFLOW_EN, Overflow_o=1. The case 0x00000003 - 0x00000001 gives Overflow_o=0.
4. Back-pressure: hold Ready_i=0 for 10 cycles in DONE -> Valid_o, Result_o and Borrow_o stay stable; concurrent Valid_i pulses are not accepted (Ready_o=0). Releasing Ready_i returns the block to IDLE, and Ready_o=1 the next cycle.
5. Reset mid-RUN: deassert Rst_ni after 2 RUN cycles -> all outputs immediately at reset values. After release, 0x00000100 - 0x000000FF with Borrow_i=1 -> Result_o=0x00000000, Borrow_o=0.
6. Configuration CHUNK=32: 0x12345678 - 0x02345678 -> Result_o=0x10000000, with Valid_o 2 edges after accept.
